// File: rtl/rgb2grey_pipe.sv
// rgb2grey_pipe: 3-stage valid/ready RGB to grey converter.
//   S1: per-channel weighted products, plus max/green bypass value
//   S2: sum of products (+ optional rounding constant)
//   S3: shift, clamp, register result
// Optional feature: define RGB2GREY_ROUND_EN for round-half-up before the
// shift; otherwise the shift truncates. Latency is 3 cycles in both builds.
module rgb2grey_pipe #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 9,
  parameter int COEF_SHIFT = 8,
  parameter int WR         = 77,
  parameter int WG         = 150,
  parameter int WB         = 29
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grey,
  output logic              sat
);

  localparam int STAGES = 3;
  localparam int PW     = DATA_W + COEF_W;      // product width
  localparam int SW     = DATA_W + COEF_W + 2;  // sum width, room for 3 terms + round

  localparam logic [COEF_W-1:0] CR   = COEF_W'(WR);
  localparam logic [COEF_W-1:0] CG   = COEF_W'(WG);
  localparam logic [COEF_W-1:0] CB   = COEF_W'(WB);
  localparam logic [COEF_W-1:0] AVGA = COEF_W'(85);
  localparam logic [COEF_W-1:0] AVGB = COEF_W'(86);
  localparam logic [SW-1:0]     MAXV = SW'({DATA_W{1'b1}});

`ifdef RGB2GREY_ROUND_EN
  localparam logic [SW-1:0] RND = SW'((2 ** COEF_SHIFT) / 2);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  // S1 payload: products for weighted modes, bypass value for max/green modes
  typedef struct packed {
    logic [PW-1:0]     pr;
    logic [PW-1:0]     pg;
    logic [PW-1:0]     pb;
    logic              byp_en;
    logic [DATA_W-1:0] byp;
  } s1_t;

  typedef struct packed {
    logic [SW-1:0]     sum;
    logic              byp_en;
    logic [DATA_W-1:0] byp;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            ld1, ld2, ld3;

  s1_t s1_c, s1_q;
  s2_t s2_q;

  logic [COEF_W-1:0] wr_s, wg_s, wb_s;
  logic [DATA_W-1:0] mx;
  logic [SW-1:0]     sum_c;
  logic [SW-1:0]     shifted;
  logic [DATA_W-1:0] grey_c;
  logic              sat_c;

  // stage load enables: a stage may load when empty or when it is draining
  always_comb begin
    ld3 = !vld_pipe[3] || out_ready;
    ld2 = !vld_pipe[2] || ld3;
    ld1 = !vld_pipe[1] || ld2;
  end

  assign in_ready  = ld1;
  assign out_valid = vld_pipe[3];

  // S1 combinational: weight select, products, max/green bypass
  always_comb begin
    wr_s = CR;
    wg_s = CG;
    wb_s = CB;
    if (mode == 2'b01) begin
      wr_s = AVGA;
      wg_s = AVGB;
      wb_s = AVGA;
    end
    mx = red;
    if (green > mx) mx = green;
    if (blue > mx)  mx = blue;
    s1_c        = '0;
    s1_c.pr     = PW'(red)   * PW'(wr_s);
    s1_c.pg     = PW'(green) * PW'(wg_s);
    s1_c.pb     = PW'(blue)  * PW'(wb_s);
    s1_c.byp_en = mode[1];
    s1_c.byp    = (mode == 2'b11) ? green : mx;
  end

  // S2 combinational: full-width sum plus rounding constant
  always_comb begin
    sum_c = SW'(s1_q.pr) + SW'(s1_q.pg) + SW'(s1_q.pb) + RND;
  end

  // S3 combinational: shift and clamp, bypass modes never saturate
  always_comb begin
    shifted = s2_q.sum >> COEF_SHIFT;
    grey_c  = shifted[DATA_W-1:0];
    sat_c   = 1'b0;
    if (s2_q.byp_en) begin
      grey_c = s2_q.byp;
    end else if (shifted > MAXV) begin
      grey_c = '1;
      sat_c  = 1'b1;
    end
  end

  // valid bits shift forward as each stage loads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      if (ld1) vld_pipe[1] <= in_valid;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // S1 register: capture accepted pixel (mode travels with it)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               s1_q <= '0;
    else if (ld1 && in_valid)   s1_q <= s1_c;
  end

  // S2 register: sum and bypass carried along
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_q <= '0;
    end else if (ld2 && vld_pipe[1]) begin
      s2_q.sum    <= sum_c;
      s2_q.byp_en <= s1_q.byp_en;
      s2_q.byp    <= s1_q.byp;
    end
  end

  // S3 register: result held stable until taken downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grey <= '0;
      sat  <= 1'b0;
    end else if (ld3 && vld_pipe[2]) begin
      grey <= grey_c;
      sat  <= sat_c;
    end
  end

endmodule

// File: doc/rgb2grey_pipe.md
RGB2GREY_PIPE -- requirements
Module: rgb2grey_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: bit width of each colour channel and of the grey output.
REQ-002 SHALL provide parameter COEF_W, default 9: unsigned width of each weight.
REQ-003 SHALL provide parameter COEF_SHIFT, default 8: weighted sum is divided by 2^COEF_SHIFT.
REQ-004 SHALL provide parameters WR, WG, WB, defaults 77, 150, 29: luma weights (BT.601, sum 256).
REQ-005 SHALL provide ports: clk  in  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL provide ports: reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL provide ports: in_valid  in  1  input pixel valid.
REQ-008 SHALL provide ports: in_ready  out  1  block accepts pixel this cycle.
REQ-009 SHALL provide ports: red, green, blue  in  DATA_W each  colour channels.
REQ-010 SHALL provide ports: mode  in  2  conversion mode, sampled with pixel.
REQ-011 SHALL provide ports: out_valid  out  1  grey result valid.
REQ-012 SHALL provide ports: out_ready  in  1  downstream accepts result.
REQ-013 SHALL provide ports: grey  out  DATA_W  grey result.
REQ-014 SHALL provide ports: sat  out  1  result was clamped (qualified by out_valid).

Function
REQ-015 Transfer SHALL occur on a clock edge where valid and ready are both high; unaccepted out_valid/grey/sat SHALL hold stable.
REQ-016 Pipeline SHALL be 3 registered stages: S1 products, S2 sum (+ rounding), S3 shift/clamp; latency in_valid accept -> out_valid = 3 cycles without stall.
REQ-017 Each stage SHALL hold a valid bit and advance when the next stage is empty or advancing; in_ready = !v1 || adv1 (bubbles collapse, throughput 1 pixel/cycle).
REQ-018 Mode 00: sum = WR*red + WG*green + WB*blue.
REQ-019 Mode 01 (average): weights 85, 86, 85 on red, green, blue, independent of WR/WG/WB.
REQ-020 Mode 10: result = max(red, green, blue), sat = 0, computed in S1 and carried unchanged.
REQ-021 Mode 11: result = green passthrough, sat = 0.
REQ-022 Mode SHALL travel with its pixel; mode changes never affect in-flight pixels.
REQ-023 Sum width SHALL be DATA_W+COEF_W+2 bits; no intermediate overflow for any legal input.
REQ-024 Shifted result > 2^DATA_W-1 SHALL yield grey = all ones and sat = 1; otherwise sat = 0.
REQ-025 Simultaneous output accept and input accept SHALL lose or duplicate no pixel.

Reset
REQ-026 reset_n low SHALL asynchronously clear all stage valid bits, out_valid = 0, grey = 0, sat = 0.
REQ-027 Reset mid-operation SHALL discard in-flight pixels; first pixel after reset release emerges 3 cycles after acceptance.
REQ-028 in_ready SHALL be 1 in reset and in the first cycle after release.

Configuration
REQ-029 With macro RGB2GREY_ROUND_EN defined, S2 SHALL add 2^(COEF_SHIFT-1) to the sum before shift (round half up); saturation check applies after rounding.
REQ-030 Without RGB2GREY_ROUND_EN, the shift SHALL truncate; latency unchanged in both builds.

Verification
REQ-031 Defaults, mode 00, (100,50,200) -> grey 82, sat 0, out_valid exactly 3 cycles after accept.
REQ-032 Mode 00, (0,1,0): RGB2GREY_ROUND_EN off -> 0; on -> 1.
REQ-033 Mode 01 (90,90,90) -> 90; mode 10 (10,200,30) -> 200; mode 11 (7,9,3) -> 9; back-to-back, modes interleaved, order preserved.
REQ-034 WR=WG=WB=128, mode 00, (255,255,255) -> grey 255, sat 1; (0,0,0) -> 0, sat 0.
REQ-035 Stream 10 pixels with out_ready held low 5 cycles mid-stream -> in_ready drops once 3 stages full, output held stable, all 10 results in order, no loss or duplicate.
REQ-036 Assert reset_n low with 2 pixels in flight -> out_valid 0 immediately, neither pixel emitted; next accepted pixel appears after 3 cycles.
